// File: rtl/spectrum_peak_sep_if.sv
`default_nettype none
// ============================================================================
//  Module   : spectrum_peak_sep_if
//  Purpose  : Control, modulus-RAM read port and result bundle of the
//             two-tone spectrum peak separator.
//  Revision : 1.0  initial release
// ============================================================================
interface spectrum_peak_sep_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          en;
  logic          key;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] waveA_freq;
  logic          waveA_sin;
  logic [AW-1:0] waveB_freq;
  logic          waveB_sin;
  logic          wave_valid;
  logic          peak_err;
  logic          busy;

  // separator side: issues RAM reads, publishes results
  modport master (
    input  en, key, rd_data,
    output rd_addr, waveA_freq, waveA_sin, waveB_freq, waveB_sin,
           wave_valid, peak_err, busy
  );

  // environment side: RAM read port and start/restart controls
  modport slave (
    output en, key, rd_data,
    input  rd_addr, waveA_freq, waveA_sin, waveB_freq, waveB_sin,
           wave_valid, peak_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/spectrum_peak_sep.sv
`default_nettype none
// ============================================================================
//  Module   : spectrum_peak_sep
//  Purpose  : Scans the half-spectrum held in the FFT-modulus RAM, keeps the
//             two strongest local peaks, orders them by bin and classifies
//             each as sine or triangle from its 3rd-harmonic magnitude.
//  Revision : 1.0  initial release
// ============================================================================
module spectrum_peak_sep #(
  parameter int N_BINS    = 256,
  parameter int DW        = 16,
  parameter int AW        = 8,
  parameter int RD_LAT    = 1,
  parameter int START_BIN = 2,
  parameter int THRESH    = 64,
  parameter int HARM_DIV  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  spectrum_peak_sep_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_HARM_A = 3'd2;
  localparam logic [2:0] S_HARM_B = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [AW-1:0] C_FIRST  = AW'(START_BIN - 1);
  localparam logic [AW-1:0] C_LAST   = AW'(N_BINS / 2 - 1);
  localparam logic [AW:0]   C_HALF   = (AW + 1)'(N_BINS / 2);
  localparam logic [DW-1:0] C_THRESH = DW'(THRESH);
  localparam logic [7:0]    C_HDIV   = 8'(HARM_DIV);
  // A's address is issued one cycle after ordering, B's on entry to HARM_B
  localparam logic [2:0]    C_WAIT_A = 3'(RD_LAT + 2);
  localparam logic [2:0]    C_WAIT_B = 3'(RD_LAT);

  logic [2:0]    state_q, state_d;
  logic          en_prev_q, en_prev_d, key_prev_q, key_prev_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          issue_q, issue_d;
  logic [RD_LAT-1:0] tag_v_q, tag_v_d;
  logic [AW-1:0] tag_a_q [RD_LAT];
  logic [AW-1:0] tag_a_d [RD_LAT];
  logic [1:0]    win_cnt_q, win_cnt_d;
  logic [DW-1:0] p_q, p_d, c_q, c_d;
  logic          t1_v_q, t1_v_d, t2_v_q, t2_v_d;
  logic [DW-1:0] t1_m_q, t1_m_d, t2_m_q, t2_m_d;
  logic [AW-1:0] t1_b_q, t1_b_d, t2_b_q, t2_b_d;
  logic          a_v_q, a_v_d, b_v_q, b_v_d, a_sin_q, a_sin_d;
  logic [DW-1:0] a_m_q, a_m_d, b_m_q, b_m_d;
  logic [AW-1:0] a_b_q, a_b_d, b_b_q, b_b_d;
  logic [2:0]    wait_q, wait_d;
  logic [AW-1:0] wa_freq_q, wa_freq_d, wb_freq_q, wb_freq_d;
  logic          wa_sin_q, wa_sin_d, wb_sin_q, wb_sin_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          w_busy;

  wire           w_en_edge  = bus.en & ~en_prev_q;
  wire           w_key_edge = bus.key & ~key_prev_q;
  wire           w_start    = (state_q == S_IDLE) & w_en_edge & ~w_key_edge;
  wire           w_dv       = tag_v_q[RD_LAT-1];
  wire  [AW-1:0] w_da       = tag_a_q[RD_LAT-1];
  wire           w_scan_end = (state_q == S_SCAN) & w_dv & (w_da == C_LAST);
  // c is the centre of the p,c,n window; n is the sample arriving now
  wire           w_is_peak  = (win_cnt_q == 2'd2) & (c_q > p_q) &
                              (c_q >= bus.rd_data) & (c_q >= C_THRESH);
  wire  [AW:0]   w_a3       = {1'b0, a_b_q} + {a_b_q, 1'b0};
  wire  [AW:0]   w_b3       = {1'b0, b_b_q} + {b_b_q, 1'b0};
  wire           w_a_in     = w_a3 < C_HALF;
  wire           w_b_in     = w_b3 < C_HALF;
  // DW+8 bits holds rd_data*255 without overflow
  wire  [DW+7:0] w_prod     = {8'd0, bus.rd_data} * {{DW{1'b0}}, C_HDIV};
  wire           w_tri_a    = w_prod > {8'd0, a_m_q};
  wire           w_tri_b    = w_prod > {8'd0, b_m_q};
  wire           w_b_sin    = b_v_q & (~w_b_in | ~w_tri_b);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic; a restart key edge overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (w_start) state_d = S_SCAN;
      S_SCAN:   if (w_scan_end) state_d = S_HARM_A;
      S_HARM_A: if (wait_q == C_WAIT_A) state_d = S_HARM_B;
      S_HARM_B: if (wait_q == C_WAIT_B) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (w_key_edge) state_d = S_IDLE;
  end

  // output decode
  always_comb begin
    w_busy = (state_q == S_SCAN) | (state_q == S_HARM_A) | (state_q == S_HARM_B);
  end

  // datapath: read sequencing, peak window, top-2 tracking, harmonic test
  always_comb begin
    en_prev_d = bus.en;     key_prev_d = bus.key;
    rd_addr_d = rd_addr_q;  issue_d    = issue_q;
    win_cnt_d = win_cnt_q;  p_d = p_q;  c_d = c_q;
    t1_v_d = t1_v_q;  t1_m_d = t1_m_q;  t1_b_d = t1_b_q;
    t2_v_d = t2_v_q;  t2_m_d = t2_m_q;  t2_b_d = t2_b_q;
    a_v_d = a_v_q;  a_m_d = a_m_q;  a_b_d = a_b_q;  a_sin_d = a_sin_q;
    b_v_d = b_v_q;  b_m_d = b_m_q;  b_b_d = b_b_q;
    wait_d = wait_q;
    wa_freq_d = wa_freq_q;  wa_sin_d = wa_sin_q;
    wb_freq_d = wb_freq_q;  wb_sin_d = wb_sin_q;
    valid_d = valid_q;      err_d = err_q;
    tag_v_d[0] = 1'b0;
    tag_a_d[0] = rd_addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_a_d[i] = tag_a_q[i-1];
    end
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          rd_addr_d = C_FIRST;  issue_d = 1'b1;  win_cnt_d = 2'd0;
          t1_v_d = 1'b0;  t2_v_d = 1'b0;
          valid_d = 1'b0; err_d = 1'b0;
        end
      end
      S_SCAN: begin
        wait_d = 3'd0;
        if (issue_q) begin
          tag_v_d[0] = 1'b1;
          if (rd_addr_q == C_LAST) issue_d = 1'b0;
          else                     rd_addr_d = rd_addr_q + AW'(1);
        end
        if (w_dv) begin
          p_d = c_q;
          c_d = bus.rd_data;
          if (win_cnt_q != 2'd2) win_cnt_d = win_cnt_q + 2'd1;
          if (w_is_peak) begin
            if (!t1_v_q || c_q > t1_m_q) begin
              t2_v_d = t1_v_q;  t2_m_d = t1_m_q;  t2_b_d = t1_b_q;
              t1_v_d = 1'b1;    t1_m_d = c_q;     t1_b_d = w_da - AW'(1);
            end else if (!t2_v_q || c_q > t2_m_q) begin
              t2_v_d = 1'b1;    t2_m_d = c_q;     t2_b_d = w_da - AW'(1);
            end
          end
        end
      end
      S_HARM_A: begin
        wait_d = wait_q + 3'd1;
        if (wait_q == 3'd0) begin
          // order by bin; a lone peak always becomes A
          a_v_d = t1_v_q;  b_v_d = t2_v_q;
          if (t2_v_q && (t2_b_q < t1_b_q)) begin
            a_m_d = t2_m_q;  a_b_d = t2_b_q;  b_m_d = t1_m_q;  b_b_d = t1_b_q;
          end else begin
            a_m_d = t1_m_q;  a_b_d = t1_v_q ? t1_b_q : '0;
            b_m_d = t2_m_q;  b_b_d = t2_v_q ? t2_b_q : '0;
          end
        end else if (wait_q == 3'd1) begin
          if (a_v_q && w_a_in) rd_addr_d = w_a3[AW-1:0];
        end
        if (wait_q == C_WAIT_A) begin
          a_sin_d = a_v_q & (~w_a_in | ~w_tri_a);
          if (b_v_q && w_b_in) rd_addr_d = w_b3[AW-1:0];
          wait_d = 3'd0;
        end
      end
      S_HARM_B: begin
        wait_d = wait_q + 3'd1;
        if (wait_q == C_WAIT_B) begin
          wa_freq_d = a_b_q;  wa_sin_d = a_sin_q;
          wb_freq_d = b_b_q;  wb_sin_d = w_b_sin;
          valid_d   = 1'b1;   err_d    = ~(a_v_q & b_v_q);
        end
      end
      default: ;
    endcase
    if (w_key_edge) begin
      issue_d = 1'b0;  tag_v_d = '0;
      wa_freq_d = '0;  wa_sin_d = 1'b0;  wb_freq_d = '0;  wb_sin_d = 1'b0;
      valid_d = 1'b0;  err_d = 1'b0;
    end
  end

  // datapath registers; edge detectors preload high so a level held through reset is not an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_prev_q <= 1'b1;  key_prev_q <= 1'b1;
      rd_addr_q <= '0;    issue_q <= 1'b0;
      tag_v_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_a_q[i] <= '0;
      win_cnt_q <= 2'd0;  p_q <= '0;  c_q <= '0;
      t1_v_q <= 1'b0;  t1_m_q <= '0;  t1_b_q <= '0;
      t2_v_q <= 1'b0;  t2_m_q <= '0;  t2_b_q <= '0;
      a_v_q <= 1'b0;  a_m_q <= '0;  a_b_q <= '0;  a_sin_q <= 1'b0;
      b_v_q <= 1'b0;  b_m_q <= '0;  b_b_q <= '0;
      wait_q <= 3'd0;
      wa_freq_q <= '0;  wa_sin_q <= 1'b0;  wb_freq_q <= '0;  wb_sin_q <= 1'b0;
      valid_q <= 1'b0;  err_q <= 1'b0;
    end else begin
      en_prev_q <= en_prev_d;  key_prev_q <= key_prev_d;
      rd_addr_q <= rd_addr_d;  issue_q <= issue_d;
      tag_v_q   <= tag_v_d;
      for (int i = 0; i < RD_LAT; i++) tag_a_q[i] <= tag_a_d[i];
      win_cnt_q <= win_cnt_d;  p_q <= p_d;  c_q <= c_d;
      t1_v_q <= t1_v_d;  t1_m_q <= t1_m_d;  t1_b_q <= t1_b_d;
      t2_v_q <= t2_v_d;  t2_m_q <= t2_m_d;  t2_b_q <= t2_b_d;
      a_v_q <= a_v_d;  a_m_q <= a_m_d;  a_b_q <= a_b_d;  a_sin_q <= a_sin_d;
      b_v_q <= b_v_d;  b_m_q <= b_m_d;  b_b_q <= b_b_d;
      wait_q <= wait_d;
      wa_freq_q <= wa_freq_d;  wa_sin_q <= wa_sin_d;
      wb_freq_q <= wb_freq_d;  wb_sin_q <= wb_sin_d;
      valid_q <= valid_d;      err_q <= err_d;
    end
  end

  assign bus.rd_addr    = rd_addr_q;
  assign bus.waveA_freq = wa_freq_q;
  assign bus.waveA_sin  = wa_sin_q;
  assign bus.waveB_freq = wb_freq_q;
  assign bus.waveB_sin  = wb_sin_q;
  assign bus.wave_valid = valid_q;
  assign bus.peak_err   = err_q;
  assign bus.busy       = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_spectrum_peak_sep.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spectrum_peak_sep
//  Purpose  : Directed self-checking bench for spectrum_peak_sep with a
//             1-cycle-latency modulus RAM model and a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spectrum_peak_sep;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spectrum_peak_sep_if #(.AW(8), .DW(16)) bus ();

  spectrum_peak_sep #(
    .N_BINS(256), .DW(16), .AW(8), .RD_LAT(1),
    .START_BIN(2), .THRESH(64), .HARM_DIV(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // modulus RAM, one clock of read latency
  logic [15:0] mem [256];
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  typedef struct packed {
    logic [7:0] fa;
    logic       sa;
    logic [7:0] fb;
    logic       sb;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
  endtask

  task automatic push_exp(input logic [7:0] fa, input logic sa,
                          input logic [7:0] fb, input logic sb, input logic err);
    exp_t e;
    e.fa = fa; e.sa = sa; e.fb = fb; e.sb = sb; e.err = err;
    sb_q.push_back(e);
  endtask

  // pulse en, optionally pulse it again at cycle dbl_at, wait for wave_valid, check against scoreboard
  task automatic run_scan(input string tag, input int dbl_at);
    int   cyc;
    exp_t e;
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk) bus.en = 1'b0;
    cyc = 1;
    chk({tag, " busy_start"}, 32'(bus.busy), 32'd1);
    chk({tag, " valid_cleared"}, 32'(bus.wave_valid), 32'd0);
    while (!bus.wave_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == dbl_at)     bus.en = 1'b1;
      if (cyc == dbl_at + 1) bus.en = 1'b0;
    end
    chk({tag, " latency_le_139"}, 32'(cyc <= 139), 32'd1);
    chk({tag, " sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, " A_freq"}, 32'(bus.waveA_freq), 32'(e.fa));
      chk({tag, " A_sin"},  32'(bus.waveA_sin),  32'(e.sa));
      chk({tag, " B_freq"}, 32'(bus.waveB_freq), 32'(e.fb));
      chk({tag, " B_sin"},  32'(bus.waveB_sin),  32'(e.sb));
      chk({tag, " err"},    32'(bus.peak_err),   32'(e.err));
      chk({tag, " busy_end"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    bus.en  = 1'b0;
    bus.key = 1'b0;
    clear_mem();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset valid",   32'(bus.wave_valid), 32'd0);
    chk("reset err",     32'(bus.peak_err),   32'd0);
    chk("reset busy",    32'(bus.busy),       32'd0);
    chk("reset A_freq",  32'(bus.waveA_freq), 32'd0);
    chk("reset B_freq",  32'(bus.waveB_freq), 32'd0);
    chk("reset sins",    32'({bus.waveA_sin, bus.waveB_sin}), 32'd0);
    chk("reset rd_addr", 32'(bus.rd_addr),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // two pure tones
    clear_mem(); mem[10] = 16'd4000; mem[25] = 16'd3000;
    push_exp(8'd10, 1'b1, 8'd25, 1'b1, 1'b0);
    run_scan("t1", 0);

    // strong 3rd harmonic on the lower tone
    clear_mem(); mem[10] = 16'd4000; mem[30] = 16'd444; mem[50] = 16'd160; mem[25] = 16'd3000;
    push_exp(8'd10, 1'b0, 8'd25, 1'b1, 1'b0);
    run_scan("t2", 0);

    // ordering is by bin, not magnitude
    clear_mem(); mem[40] = 16'd5000; mem[12] = 16'd1000;
    push_exp(8'd12, 1'b1, 8'd40, 1'b1, 1'b0);
    run_scan("t3a", 0);

    // single peak whose harmonic lies beyond the half-spectrum
    clear_mem(); mem[100] = 16'd9000;
    push_exp(8'd100, 1'b1, 8'd0, 1'b0, 1'b1);
    run_scan("t3b", 0);

    // single peak with a weak harmonic (10*32 < 500 keeps it sine)
    clear_mem(); mem[20] = 16'd500; mem[60] = 16'd10;
    push_exp(8'd20, 1'b1, 8'd0, 1'b0, 1'b1);
    run_scan("t4", 0);

    // no peaks at all
    clear_mem();
    push_exp(8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    run_scan("none", 0);

    // equal magnitudes: earliest two bins kept; bin 60 is A's harmonic
    clear_mem(); mem[20] = 16'd1000; mem[40] = 16'd1000; mem[60] = 16'd1000;
    push_exp(8'd20, 1'b0, 8'd40, 1'b1, 1'b0);
    run_scan("tie", 0);

    // bins 1 and 127 are outside the eligible range
    clear_mem(); mem[1] = 16'd3000; mem[127] = 16'd7000; mem[50] = 16'd500; mem[70] = 16'd600;
    push_exp(8'd50, 1'b1, 8'd70, 1'b1, 1'b0);
    run_scan("edges_out", 0);

    // first and last eligible bins
    clear_mem(); mem[2] = 16'd1000; mem[126] = 16'd2000;
    push_exp(8'd2, 1'b1, 8'd126, 1'b1, 1'b0);
    run_scan("edges_in", 0);

    // restart key 40 cycles into a scan
    clear_mem(); mem[10] = 16'd4000; mem[25] = 16'd3000;
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk) bus.en = 1'b0;
    repeat (39) @(negedge clk);
    chk("t5 busy_before_key", 32'(bus.busy), 32'd1);
    bus.key = 1'b1;
    @(negedge clk);
    chk("t5 key busy",   32'(bus.busy),       32'd0);
    chk("t5 key valid",  32'(bus.wave_valid), 32'd0);
    chk("t5 key A_freq", 32'(bus.waveA_freq), 32'd0);
    chk("t5 key B_freq", 32'(bus.waveB_freq), 32'd0);
    bus.key = 1'b0;
    repeat (2) @(negedge clk);
    push_exp(8'd10, 1'b1, 8'd25, 1'b1, 1'b0);
    run_scan("t5 rerun", 0);

    // en held high across reset release is not a start
    bus.en = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6 en_level busy",  32'(bus.busy),       32'd0);
    chk("t6 en_level valid", 32'(bus.wave_valid), 32'd0);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);

    // second en edge while busy is ignored; no rerun afterwards
    push_exp(8'd10, 1'b1, 8'd25, 1'b1, 1'b0);
    run_scan("t6 dbl_en", 20);
    repeat (3) @(negedge clk);
    chk("t6 no_restart busy",  32'(bus.busy),       32'd0);
    chk("t6 no_restart valid", 32'(bus.wave_valid), 32'd1);

    // reset during the harmonic phase wipes everything
    @(negedge clk) bus.en = 1'b1;
    @(negedge clk) bus.en = 1'b0;
    repeat (130) @(negedge clk);
    chk("t6 busy_in_harm", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6 rst busy",   32'(bus.busy),       32'd0);
    chk("t6 rst valid",  32'(bus.wave_valid), 32'd0);
    chk("t6 rst err",    32'(bus.peak_err),   32'd0);
    chk("t6 rst A_freq", 32'(bus.waveA_freq), 32'd0);
    chk("t6 rst B_freq", 32'(bus.waveB_freq), 32'd0);
    chk("t6 rst sins",   32'({bus.waveA_sin, bus.waveB_sin}), 32'd0);
    chk("t6 rst rd_addr", 32'(bus.rd_addr),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("sb drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
